// File: rtl/quiz_pkg.sv
// quiz_pkg: shared state encoding and helpers for the quiz match controller.
// Encodings are fixed so downstream display decoders can rely on them.
package quiz_pkg;

  localparam int STATE_W = 3;
  localparam int PC_W    = 8;

  typedef enum logic [STATE_W-1:0] {
    IDLE       = 3'd0,
    WAIT_READY = 3'd1,
    LOAD_Q     = 3'd2,
    ANSWER     = 3'd3,
    JUDGE      = 3'd4,
    RESULT     = 3'd5,
    OVER       = 3'd6
  } state_t;

  function automatic logic [3:0] popcount(
    input logic [PC_W-1:0] v
  );
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < PC_W; i++)
      n = n + {3'b000, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/quiz_tick_timer.sv
// quiz_tick_timer: TICK_DIV prescaler plus loadable tick down-counter.
// Ports: clk, rst_n, load/ticks (arm), stop (abort), expire (final tick).
module quiz_tick_timer #(
  parameter int TICK_DIV = 50000000,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             stop,
  input  logic [CNT_W-1:0] ticks,
  output logic             expire
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]    pre_q;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;
  logic             tick;

  assign tick   = run_q && (pre_q == PLAST);
  // Expire coincides with the last prescaler cycle so the owner
  // leaves its state exactly when the final tick completes.
  assign expire = tick && (cnt_q <= CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (load) begin
      pre_q <= '0;
      cnt_q <= ticks;
      run_q <= 1'b1;
    end else if (stop || expire) begin
      pre_q <= '0;
      run_q <= 1'b0;
    end else if (run_q) begin
      if (tick) begin
        pre_q <= '0;
        cnt_q <= cnt_q - CNT_W'(1);
      end else begin
        pre_q <= pre_q + PW'(1);
      end
    end
  end

endmodule

// File: rtl/quiz_match_ctrl.sv
// quiz_match_ctrl: N-player round sequencer, arbitration and HP bookkeeping.
// In: START, READY, ANS_VALID/ANS_OK, Q_ACK. Out: Q_REQ/Q_IDX, STATE, HP, flags.
module quiz_match_ctrl
  import quiz_pkg::*;
#(
  parameter int NPLAYER      = 2,
  parameter int HP_W         = 2,
  parameter int HP_INIT      = 3,
  parameter int QIDX_W       = 4,
  parameter int TICK_DIV     = 50000000,
  parameter int ANSWER_TICKS = 10,
  parameter int RESULT_TICKS = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     START,
  input  logic [NPLAYER-1:0]       READY,
  input  logic [NPLAYER-1:0]       ANS_VALID,
  input  logic [NPLAYER-1:0]       ANS_OK,
  input  logic                     Q_ACK,
  output logic                     Q_REQ,
  output logic [QIDX_W-1:0]        Q_IDX,
  output logic [STATE_W-1:0]       STATE,
  output logic [NPLAYER*HP_W-1:0]  HP,
  output logic [NPLAYER-1:0]       ALIVE,
  output logic [NPLAYER-1:0]       ANSWERER,
  output logic                     TIMEOUT,
  output logic [NPLAYER-1:0]       WINNER,
  output logic                     DRAW
);

  localparam int TMAX  = (ANSWER_TICKS > RESULT_TICKS) ?
                         ANSWER_TICKS : RESULT_TICKS;
  localparam int CNT_W = $clog2(TMAX + 1);

  typedef logic [NPLAYER-1:0][HP_W-1:0] hp_arr_t;

  state_t            state_q, state_n;
  hp_arr_t           hp_q, hp_n;
  logic [NPLAYER-1:0] alive_q, alive_n;
  logic [NPLAYER-1:0] mask_q, mask_n;
  logic [QIDX_W-1:0] qidx_q, qidx_n;
  logic              qreq_q, qreq_n;
  logic [NPLAYER-1:0] ans_q, ans_n;
  logic              ok_q, ok_n;
  logic              to_q, to_n;
  logic [NPLAYER-1:0] win_q, win_n;
  logic              draw_q, draw_n;

  logic [NPLAYER-1:0] valid;
  logic [NPLAYER-1:0] first;
  logic [3:0]        n_alive;
  logic              t_load, t_stop, t_expire;
  logic [CNT_W-1:0]  t_ticks;

  function automatic logic [HP_W-1:0] dec(
    input logic [HP_W-1:0] h
  );
    return (h == '0) ? h : h - HP_W'(1);
  endfunction

  quiz_tick_timer #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_timer (
    .clk    (CLK),
    .rst_n  (RST),
    .load   (t_load),
    .stop   (t_stop),
    .ticks  (t_ticks),
    .expire (t_expire)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      hp_q    <= '0;
      alive_q <= '0;
      mask_q  <= '0;
      qidx_q  <= '0;
      qreq_q  <= 1'b0;
      ans_q   <= '0;
      ok_q    <= 1'b0;
      to_q    <= 1'b0;
      win_q   <= '0;
      draw_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      hp_q    <= hp_n;
      alive_q <= alive_n;
      mask_q  <= mask_n;
      qidx_q  <= qidx_n;
      qreq_q  <= qreq_n;
      ans_q   <= ans_n;
      ok_q    <= ok_n;
      to_q    <= to_n;
      win_q   <= win_n;
      draw_q  <= draw_n;
    end
  end

  always_comb begin
    state_n = state_q;
    hp_n    = hp_q;
    mask_n  = mask_q;
    qidx_n  = qidx_q;
    qreq_n  = 1'b0;
    ans_n   = ans_q;
    ok_n    = ok_q;
    to_n    = to_q;
    win_n   = win_q;
    draw_n  = draw_q;
    t_load  = 1'b0;
    t_stop  = 1'b0;
    t_ticks = '0;
    alive_n = '0;
    valid   = ANS_VALID & alive_q;
    // Isolate the lowest set bit: lowest index wins a tie.
    first   = valid & (~valid + NPLAYER'(1));
    n_alive = popcount(PC_W'(alive_q));

    unique case (state_q)
      IDLE, OVER: begin
        if (START) begin
          state_n = WAIT_READY;
          for (int i = 0; i < NPLAYER; i++)
            hp_n[i] = HP_W'(HP_INIT);
          qidx_n = '0;
          mask_n = '0;
          ans_n  = '0;
          ok_n   = 1'b0;
          to_n   = 1'b0;
          win_n  = '0;
          draw_n = 1'b0;
        end
      end
      WAIT_READY: begin
        mask_n = mask_q | (READY & alive_q);
        if ((mask_n & alive_q) == alive_q) begin
          state_n = LOAD_Q;
          qreq_n  = 1'b1;
        end
      end
      LOAD_Q: begin
        if (Q_ACK) begin
          state_n = ANSWER;
          t_load  = 1'b1;
          t_ticks = CNT_W'(ANSWER_TICKS);
        end
      end
      ANSWER: begin
        // An answer on the final tick takes priority over expiry.
        if (|valid) begin
          state_n = JUDGE;
          ans_n   = first;
          ok_n    = |(ANS_OK & first);
          t_stop  = 1'b1;
        end else if (t_expire) begin
          state_n = JUDGE;
          ans_n   = '0;
          ok_n    = 1'b0;
        end
      end
      JUDGE: begin
        for (int i = 0; i < NPLAYER; i++) begin
          if (ans_q == '0)
            hp_n[i] = dec(hp_q[i]);
          else if (ok_q && !ans_q[i])
            hp_n[i] = dec(hp_q[i]);
          else if (!ok_q && ans_q[i])
            hp_n[i] = dec(hp_q[i]);
        end
        to_n    = (ans_q == '0);
        state_n = RESULT;
        t_load  = 1'b1;
        t_ticks = CNT_W'(RESULT_TICKS);
      end
      RESULT: begin
        if (t_expire) begin
          ans_n = '0;
          ok_n  = 1'b0;
          to_n  = 1'b0;
          if (n_alive <= 4'd1) begin
            state_n = OVER;
            win_n   = (n_alive == 4'd1) ? alive_q : '0;
            draw_n  = (n_alive == 4'd0);
          end else begin
            state_n = WAIT_READY;
            qidx_n  = qidx_q + QIDX_W'(1);
            mask_n  = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    for (int i = 0; i < NPLAYER; i++)
      alive_n[i] = |hp_n[i];
  end

  assign STATE    = state_q;
  assign HP       = hp_q;
  assign ALIVE    = alive_q;
  assign Q_REQ    = qreq_q;
  assign Q_IDX    = qidx_q;
  assign ANSWERER = ans_q;
  assign TIMEOUT  = to_q;
  assign WINNER   = win_q;
  assign DRAW     = draw_q;

endmodule

// File: tb/tb_quiz_match_ctrl.sv
// tb_quiz_match_ctrl: scoreboard bench for quiz_match_ctrl.
// Stimulus pushes expected round outcomes; a negedge monitor pops them.
module tb_quiz_match_ctrl;
  import quiz_pkg::*;

  localparam int NP  = 2;
  localparam int HPW = 2;
  localparam int HPI = 3;
  localparam int QW  = 1;
  localparam int TD  = 4;
  localparam int AT  = 5;
  localparam int RT  = 2;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic START = 1'b0;
  logic Q_ACK = 1'b0;
  logic [NP-1:0] READY = '0;
  logic [NP-1:0] ANS_VALID = '0;
  logic [NP-1:0] ANS_OK = '0;
  logic Q_REQ;
  logic [QW-1:0] Q_IDX;
  logic [2:0] STATE;
  logic [NP*HPW-1:0] HP;
  logic [NP-1:0] ALIVE;
  logic [NP-1:0] ANSWERER;
  logic TIMEOUT;
  logic [NP-1:0] WINNER;
  logic DRAW;

  quiz_match_ctrl #(
    .NPLAYER(NP), .HP_W(HPW), .HP_INIT(HPI), .QIDX_W(QW),
    .TICK_DIV(TD), .ANSWER_TICKS(AT), .RESULT_TICKS(RT)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START), .READY(READY),
    .ANS_VALID(ANS_VALID), .ANS_OK(ANS_OK), .Q_ACK(Q_ACK),
    .Q_REQ(Q_REQ), .Q_IDX(Q_IDX), .STATE(STATE), .HP(HP),
    .ALIVE(ALIVE), .ANSWERER(ANSWERER), .TIMEOUT(TIMEOUT),
    .WINNER(WINNER), .DRAW(DRAW)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit         over;
    logic [1:0] ans;
    bit         to;
    logic [3:0] hp;
    logic [1:0] alive;
    logic       qidx;
    logic [1:0] win;
    bit         draw;
  } exp_t;

  exp_t sbq[$];
  exp_t cur;
  int n_chk = 0;
  int n_fail = 0;
  int hp_m[NP];
  int qidx_m = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_st(input logic [2:0] s, input int lim);
    int k;
    k = 0;
    while (STATE !== s) begin
      if (k == lim) begin
        n_chk++;
        n_fail++;
        $display("FAIL wait_state: got %0h expected %0h", STATE, s);
        finish_run();
      end
      step();
      k++;
    end
  endtask

  // Reference model: HP as plain integers, alive means HP above zero.
  function automatic logic [1:0] m_alive();
    logic [1:0] r;
    for (int i = 0; i < NP; i++) r[i] = (hp_m[i] > 0);
    return r;
  endfunction

  function automatic logic [3:0] m_hp();
    logic [3:0] r;
    for (int i = 0; i < NP; i++) r[i*HPW +: HPW] = 2'(hp_m[i]);
    return r;
  endfunction

  function automatic int m_count();
    int n;
    n = 0;
    for (int i = 0; i < NP; i++) if (hp_m[i] > 0) n++;
    return n;
  endfunction

  function automatic int lose1(input int h);
    return (h > 0) ? h - 1 : 0;
  endfunction

  task automatic model_round(input bit to, input logic [1:0] v,
                             input logic [1:0] ok);
    exp_t e;
    logic [1:0] el;
    int w, na;
    el = v & m_alive();
    w = -1;
    if (!to)
      for (int i = NP - 1; i >= 0; i--) if (el[i]) w = i;
    e.qidx = qidx_m[0];
    if (w < 0) begin
      for (int i = 0; i < NP; i++) hp_m[i] = lose1(hp_m[i]);
      e.ans = 2'b00;
      e.to = 1'b1;
    end else begin
      e.ans = 2'(1 << w);
      e.to = 1'b0;
      if (ok[w]) begin
        for (int j = 0; j < NP; j++)
          if (j != w) hp_m[j] = lose1(hp_m[j]);
      end else begin
        hp_m[w] = lose1(hp_m[w]);
      end
    end
    e.over = 1'b0;
    e.hp = m_hp();
    e.alive = m_alive();
    e.win = 2'b00;
    e.draw = 1'b0;
    sbq.push_back(e);
    na = m_count();
    if (na <= 1) begin
      e.over = 1'b1;
      e.win = (na == 1) ? m_alive() : 2'b00;
      e.draw = (na == 0);
      sbq.push_back(e);
    end else begin
      qidx_m = (qidx_m + 1) % (1 << QW);
    end
  endtask

  logic [2:0] prev_st = 3'd0;

  always @(negedge CLK) begin
    if (!RST) begin
      prev_st = 3'd0;
    end else begin
      if (Q_REQ)
        chk("qreq_first", {30'd0, STATE == LOAD_Q, prev_st != LOAD_Q}, 3);
      if (STATE == RESULT && prev_st != RESULT) begin
        if (sbq.size() == 0) begin
          chk("sb_underflow_result", 1, 0);
        end else begin
          cur = sbq.pop_front();
          chk("rec_kind", {31'd0, cur.over}, 0);
          chk("answerer", ANSWERER, cur.ans);
          chk("timeout", TIMEOUT, cur.to);
          chk("hp_after", HP, cur.hp);
          chk("alive", ALIVE, cur.alive);
          chk("q_idx", Q_IDX, cur.qidx);
        end
      end else if (STATE == RESULT) begin
        chk("result_hold", {ANSWERER, TIMEOUT}, {cur.ans, cur.to});
      end
      if (STATE == OVER && prev_st != OVER) begin
        if (sbq.size() == 0) begin
          chk("sb_underflow_over", 1, 0);
        end else begin
          cur = sbq.pop_front();
          chk("over_kind", {31'd0, cur.over}, 1);
          chk("winner", WINNER, cur.win);
          chk("draw", DRAW, cur.draw);
          chk("over_hp", HP, cur.hp);
        end
      end
      prev_st = STATE;
    end
  end

  task automatic do_start();
    START = 1'b1;
    step();
    START = 1'b0;
    for (int i = 0; i < NP; i++) hp_m[i] = HPI;
    qidx_m = 0;
    chk("start_state", STATE, WAIT_READY);
    chk("start_hp", HP, m_hp());
  endtask

  task automatic round(input bit to, input logic [1:0] v,
                       input logic [1:0] ok, input int d, input int gap,
                       input int qd, input bit rev, input bit junk);
    logic [1:0] al;
    int ord[2];
    int last, k;
    wait_st(WAIT_READY, 60);
    al = m_alive();
    ord[0] = rev ? 1 : 0;
    ord[1] = rev ? 0 : 1;
    last = al[ord[1]] ? 1 : 0;
    for (int i = 0; i < 2; i++) begin
      if (al[ord[i]]) begin
        READY = 2'(1 << ord[i]);
        step();
        READY = '0;
        if (i == last)
          chk("ready_to_loadq", {Q_REQ, STATE}, {1'b1, LOAD_Q});
        else
          repeat (gap) step();
      end
    end
    repeat (qd) step();
    Q_ACK = 1'b1;
    step();
    Q_ACK = 1'b0;
    chk("load_to_answer", STATE, ANSWER);
    if (to) begin
      model_round(1'b1, 2'b00, 2'b00);
      k = 0;
      while (STATE == ANSWER && k < 40) begin
        step();
        k++;
      end
      chk("window_len", k, AT * TD);
    end else begin
      if (junk && d >= 2) begin
        START = 1'b1;
        READY = 2'($urandom_range(0, 3));
        step();
        START = 1'b0;
        READY = '0;
        repeat (d - 1) step();
      end else begin
        repeat (d) step();
      end
      model_round(1'b0, v, ok);
      ANS_VALID = v;
      ANS_OK = ok;
      step();
      ANS_VALID = '0;
      ANS_OK = '0;
    end
    chk("to_judge", STATE, JUDGE);
    k = 0;
    while ((STATE == JUDGE || STATE == RESULT) && k < 40) begin
      step();
      k++;
    end
    chk("result_len", k, 1 + RT * TD);
  endtask

  task automatic over_ignore();
    wait_st(OVER, 60);
    ANS_VALID = 2'b10;
    ANS_OK = 2'b10;
    READY = 2'b11;
    Q_ACK = 1'b1;
    step();
    ANS_VALID = '0;
    ANS_OK = '0;
    READY = '0;
    Q_ACK = 1'b0;
    repeat (3) step();
    chk("over_hold_state", STATE, OVER);
    chk("over_hold_hp", HP, m_hp());
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end expected end");
    $fatal(1, "watchdog");
  end

  initial begin
    bit to;
    logic [1:0] v, ok;
    int d;
    RST = 1'b0;
    repeat (3) step();
    chk("rst_state", STATE, IDLE);
    chk("rst_hp", HP, 0);
    chk("rst_outs", {Q_REQ, Q_IDX, ALIVE, ANSWERER, TIMEOUT, WINNER, DRAW}, 0);
    RST = 1'b1;
    step();

    // Reach ANSWER, then pull reset mid-window.
    do_start();
    READY = 2'b01; step(); READY = '0;
    repeat (2) step();
    READY = 2'b10; step(); READY = '0;
    repeat (2) step();
    Q_ACK = 1'b1; step(); Q_ACK = 1'b0;
    chk("pre_reset_answer", STATE, ANSWER);
    repeat (5) step();
    #2 RST = 1'b0;
    #1;
    chk("async_rst_state", STATE, IDLE);
    chk("async_rst_hp", HP, 0);
    chk("async_rst_qreq", Q_REQ, 0);
    step();
    RST = 1'b1;
    step();

    // Directed game: tie, wrong answer, timeout -> P0 wins.
    do_start();
    round(1'b0, 2'b11, 2'b01, 3, 2, 2, 1'b0, 1'b0);
    round(1'b0, 2'b10, 2'b00, 0, 0, 0, 1'b1, 1'b0);
    round(1'b1, 2'b00, 2'b00, 0, 1, 1, 1'b0, 1'b0);
    over_ignore();

    // Draw by repeated timeouts.
    do_start();
    round(1'b1, 2'b00, 2'b00, 0, 0, 0, 1'b0, 1'b0);
    round(1'b1, 2'b00, 2'b00, 0, 3, 3, 1'b1, 1'b0);
    round(1'b1, 2'b00, 2'b00, 0, 1, 0, 1'b0, 1'b0);
    over_ignore();

    // Answer landing on the final tick beats expiry.
    do_start();
    round(1'b0, 2'b10, 2'b10, AT * TD - 1, 0, 0, 1'b0, 1'b0);

    // Randomised games.
    for (int g = 0; g < 8; g++) begin
      if (g > 0) do_start();
      while (m_count() > 1) begin
        to = ($urandom_range(0, 3) == 0);
        v = 2'($urandom_range(1, 3));
        ok = 2'($urandom_range(0, 3));
        d = $urandom_range(0, AT * TD - 1);
        if ($urandom_range(0, 4) == 0) d = AT * TD - 1;
        round(to, v, ok, d, $urandom_range(0, 4), $urandom_range(0, 3),
              1'($urandom_range(0, 1)), 1'b1);
      end
      over_ignore();
    end

    repeat (5) step();
    chk("sb_empty", sbq.size(), 0);
    finish_run();
  end

endmodule
